// File: rtl/spart_pkg.sv
// Shared SPART types and default constants (used by the transmitter and receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spart_pkg;

    // Default frame geometry; the receiver reuses these.
    localparam int SPART_OVERSAMPLE = 16;
    localparam int SPART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/spart_tx_if.sv
// Host/baud-side bundle for the SPART transmitter: baud tick, write strobe and byte in; serial line and ready flag out.
// Latency: n/a (wires only).
// Backpressure: tbr low means tx_load is ignored; the master must wait for tbr before writing.
interface spart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 enable;   // one-clk baud tick (OVERSAMPLE x bit rate)
    logic                 tx_load;  // one-clk write strobe
    logic [DATA_BITS-1:0] tx_data;  // byte sampled with tx_load
    logic                 txd;      // serial line, idle high
    logic                 tbr;      // holding register empty

    modport master (output enable, tx_load, tx_data, input  txd, tbr);
    modport slave  (input  enable, tx_load, tx_data, output txd, tbr);
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding register feeding an 8N1 shifter, clocked by an external baud tick.
// Latency: write accepted at edge t -> start bit on txd and tbr high after edge t+1.
// Backpressure: tbr low while the holding register is full; writes during that time are dropped.
// Ports: clk, rst (sync, active high); bus.slave carries enable, tx_load, tx_data in and txd, tbr out.
module spart_tx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int DATA_BITS  = SPART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    spart_tx_if.slave bus
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1)  ? $clog2(DATA_BITS)  : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_tbr;    // holding register empty (inverse of full)
    logic                 r_txd;

    tx_state_t            w_state_nxt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_hold_nxt;
    logic                 w_tbr_nxt;
    logic                 w_txd_nxt;
    logic                 w_bit_end;
    logic                 w_xfer;   // move holding byte into the shifter this edge

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_hold_nxt  = r_hold;
        w_tbr_nxt   = r_tbr;
        w_txd_nxt   = 1'b1;
        w_xfer      = 1'b0;
        w_bit_end   = bus.enable && (r_tick == TICK_LAST);

        // A write is only taken while the holding register is empty. During a
        // transfer r_tbr is still 0, so a write in that cycle is dropped.
        if (bus.tx_load && r_tbr) begin
            w_hold_nxt = bus.tx_data;
            w_tbr_nxt  = 1'b0;
        end

        // Tick counter runs only inside a bit and only on baud ticks.
        if ((r_state != IDLE) && bus.enable) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick + 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                w_xfer = !r_tbr;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    // Held byte goes straight into a new start bit, no idle gap.
                    if (!r_tbr) begin
                        w_xfer = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_xfer) begin
            w_state_nxt = START;
            w_shift_nxt = r_hold;
            w_tbr_nxt   = 1'b1;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
        end

        // txd is registered from the next state so the line changes on the
        // same edge as the state.
        unique case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_hold  <= '0;
            r_tbr   <= 1'b1;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_hold  <= w_hold_nxt;
            r_tbr   <= w_tbr_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    assign bus.txd = r_txd;
    assign bus.tbr = r_tbr;

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: directed scenarios plus random traffic against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spart_tx;

    localparam int OVS       = 16;
    localparam int DBITS     = 8;
    localparam int FRAME_EN  = (DBITS + 2) * OVS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_tx_if #(.DATA_BITS(DBITS)) bus ();

    spart_tx #(.OVERSAMPLE(OVS), .DATA_BITS(DBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int en_period = 1;
    int phase     = 0;

    // Frame-level reference: a frame is a byte plus a count of baud ticks since
    // its start bit began; the line value is picked from the bit index n/OVS.
    bit             m_busy = 0;
    int             m_n    = 0;
    logic [7:0]     m_byte = '0;
    bit             m_held = 0;
    logic [7:0]     m_hold = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, obs, exp);
    endtask

    function automatic logic m_txd();
        int k;
        if (!m_busy) return 1'b1;
        k = m_n / OVS;
        if (k == 0) return 1'b0;
        if (k <= DBITS) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit was_held;
        was_held = m_held;
        if (rst) begin
            m_busy = 0; m_n = 0; m_held = 0;
        end else begin
            if (m_busy) begin
                if (bus.enable) begin
                    m_n++;
                    if (m_n == FRAME_EN) begin
                        m_n = 0;
                        if (m_held) begin
                            m_byte = m_hold; m_held = 0;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end else if (m_held) begin
                m_busy = 1; m_byte = m_hold; m_held = 0; m_n = 0;
            end
            if (bus.tx_load && !was_held) begin
                m_held = 1; m_hold = bus.tx_data;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_n++;
        chk("txd", {31'd0, bus.txd}, {31'd0, m_txd()});
        chk("tbr", {31'd0, bus.tbr}, {31'd0, !m_held});
    endtask

    task automatic cyc(input bit ld, input logic [7:0] d);
        bus.enable  = (en_period != 0) && ((phase % en_period) == 0);
        phase++;
        bus.tx_load = ld;
        bus.tx_data = d;
        step();
        bus.tx_load = 1'b0;
    endtask

    initial begin
        int t_fall, t_rise, t_fall2, guard, changes;
        logic prev;
        bus.enable  = 1'b0;
        bus.tx_load = 1'b0;
        bus.tx_data = '0;

        // Reset state
        rst = 1'b1;
        cyc(0, 8'h00);
        cyc(0, 8'h00);
        chk("rst_txd", {31'd0, bus.txd}, 32'd1);
        chk("rst_tbr", {31'd0, bus.tbr}, 32'd1);
        rst = 1'b0;
        cyc(0, 8'h00);

        // Single frame 0xA5, tick every clk
        en_period = 1;
        cyc(1, 8'hA5);
        cyc(0, 8'h00);
        chk("a5_start", {31'd0, bus.txd}, 32'd0);
        chk("a5_tbr", {31'd0, bus.tbr}, 32'd1);
        repeat (170) cyc(0, 8'h00);

        // Back-to-back 0x3C then 0xC3
        cyc(1, 8'h3C);
        repeat (40) cyc(0, 8'h00);
        cyc(1, 8'hC3);
        repeat (340) cyc(0, 8'h00);

        // Writes while full (and in the transfer cycle) are dropped
        cyc(1, 8'h5A);
        cyc(1, 8'h11);
        repeat (20) cyc(0, 8'h00);
        cyc(1, 8'h77);
        repeat (5) cyc(0, 8'h00);
        cyc(1, 8'h11);
        chk("full_tbr", {31'd0, bus.tbr}, 32'd0);
        repeat (340) cyc(0, 8'h00);

        // Tick every 4th clk: start bit 64 clk, frame 640 clk
        en_period = 4; phase = 3;
        cyc(1, 8'hFF);
        cyc(0, 8'h00);
        t_fall = cyc_n;
        cyc(1, 8'h00);
        guard = 0;
        while (bus.txd == 1'b0 && guard < 200) begin cyc(0, 8'h00); guard++; end
        t_rise = cyc_n;
        chk("start_len", t_rise - t_fall, 32'd64);
        guard = 0;
        while (bus.txd == 1'b1 && guard < 1000) begin cyc(0, 8'h00); guard++; end
        t_fall2 = cyc_n;
        chk("frame_len", t_fall2 - t_fall, 32'd640);
        repeat (700) cyc(0, 8'h00);

        // Reset mid-frame of 0x55, then quiet line
        en_period = 1;
        cyc(1, 8'h55);
        repeat (70) cyc(0, 8'h00);
        rst = 1'b1;
        cyc(1, 8'h99);
        rst = 1'b0;
        chk("abort_txd", {31'd0, bus.txd}, 32'd1);
        chk("abort_tbr", {31'd0, bus.tbr}, 32'd1);
        changes = 0;
        prev = bus.txd;
        repeat (200) begin
            cyc(0, 8'h00);
            if (bus.txd !== prev) changes++;
            prev = bus.txd;
        end
        chk("quiet_after_rst", changes, 32'd0);

        // Reset while a byte is held discards it
        cyc(1, 8'hF0);
        repeat (30) cyc(0, 8'h00);
        cyc(1, 8'h0F);
        rst = 1'b1;
        cyc(0, 8'h00);
        rst = 1'b0;
        repeat (200) cyc(0, 8'h00);

        // Baud tick stopped: start bit held indefinitely, then resumes
        en_period = 0;
        cyc(1, 8'h80);
        repeat (300) cyc(0, 8'h00);
        chk("stall_txd", {31'd0, bus.txd}, 32'd0);
        en_period = 1;
        repeat (170) cyc(0, 8'h00);

        // Random traffic
        for (int blk = 0; blk < 12; blk++) begin
            en_period = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            for (int i = 0; i < 250; i++) begin
                rst = ($urandom_range(0, 999) == 0);
                cyc($urandom_range(0, 29) == 0, 8'($urandom));
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
